// File: rtl/eq_adapt_sequencer_if.sv
// Bundle of handshake signals between the equalizer adaptation sequencer,
// the eye monitor and the parameter-update block.
interface eq_adapt_sequencer_if #(
    parameter int unsigned OPEN_W = 16,
    parameter int unsigned ITER_W = 6
);
    // Control and eye-monitor inputs to the sequencer
    logic              start;
    logic              abort;
    logic [OPEN_W-1:0] opening;
    logic              opening_ready;

    // Sequencer outputs
    logic              measure_start;
    logic              update_en;
    logic              adapt_busy;
    logic              adapt_done;
    logic              adapt_fail;
    logic              fail_timeout;
    logic [ITER_W-1:0] iter_count;
    logic [OPEN_W-1:0] best_opening;

    // Driver / observer side (controller host, eye monitor, bench)
    modport master (
        output start,
        output abort,
        output opening,
        output opening_ready,
        input  measure_start,
        input  update_en,
        input  adapt_busy,
        input  adapt_done,
        input  adapt_fail,
        input  fail_timeout,
        input  iter_count,
        input  best_opening
    );

    // Sequencer side
    modport slave (
        input  start,
        input  abort,
        input  opening,
        input  opening_ready,
        output measure_start,
        output update_en,
        output adapt_busy,
        output adapt_done,
        output adapt_fail,
        output fail_timeout,
        output iter_count,
        output best_opening
    );
endinterface

// File: rtl/eq_adapt_sequencer.sv
// TX equalizer adaptation sequencer: settle, request an eye measurement,
// then pulse a parameter-update step until the eye opening meets target for
// CONV_COUNT consecutive measurements, or the iteration/timeout limits hit.
module eq_adapt_sequencer #(
    parameter int unsigned       OPEN_W       = 16,
    parameter logic [OPEN_W-1:0] TARGET       = OPEN_W'(1000),
    parameter int unsigned       SETTLE_CYC   = 8,
    parameter int unsigned       MEAS_TIMEOUT = 64,
    parameter int unsigned       CONV_COUNT   = 3,
    parameter int unsigned       MAX_ITER     = 32,
    parameter int unsigned       ITER_W       = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    eq_adapt_sequencer_if.slave  bus
);

    localparam int unsigned SETTLE_W = (SETTLE_CYC   > 1) ? $clog2(SETTLE_CYC)   : 1;
    localparam int unsigned TMO_W    = (MEAS_TIMEOUT > 1) ? $clog2(MEAS_TIMEOUT) : 1;
    localparam int unsigned GOOD_W   = $clog2(CONV_COUNT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_UPDATE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t              r_state;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic [ITER_W-1:0]   r_iter_count;
    logic [OPEN_W-1:0]   r_best_opening;
    logic                r_measure_start;
    logic                r_update_en;
    logic                r_adapt_busy;
    logic                r_adapt_done;
    logic                r_adapt_fail;
    logic                r_fail_timeout;

    logic                w_open_good;
    logic [GOOD_W-1:0]   w_good_next;
    logic                w_converged;
    logic                w_iter_limit;
    logic                w_tmo_hit;
    logic                w_settle_zero;
    logic                w_start_ok;

    assign w_open_good   = (bus.opening >= TARGET);
    assign w_good_next   = w_open_good ? (r_good_cnt + 1'b1) : '0;
    assign w_converged   = (w_good_next == GOOD_W'(CONV_COUNT));
    assign w_iter_limit  = (r_iter_count == ITER_W'(MAX_ITER));
    assign w_tmo_hit     = (r_tmo_cnt == TMO_W'(MEAS_TIMEOUT - 1));
    assign w_settle_zero = (r_settle_cnt == '0);
    assign w_start_ok    = bus.start &&
                           ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAIL));

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_settle_cnt    <= '0;
            r_tmo_cnt       <= '0;
            r_good_cnt      <= '0;
            r_iter_count    <= '0;
            r_best_opening  <= '0;
            r_measure_start <= 1'b0;
            r_update_en     <= 1'b0;
            r_adapt_busy    <= 1'b0;
            r_adapt_done    <= 1'b0;
            r_adapt_fail    <= 1'b0;
            r_fail_timeout  <= 1'b0;
        end else begin
            // Strobes default low; set only on the edge entering their state
            r_measure_start <= 1'b0;
            r_update_en     <= 1'b0;

            if (bus.abort) begin
                // iter_count and best_opening intentionally kept for debug
                r_state        <= S_IDLE;
                r_adapt_busy   <= 1'b0;
                r_adapt_done   <= 1'b0;
                r_adapt_fail   <= 1'b0;
                r_fail_timeout <= 1'b0;
            end else if (w_start_ok) begin
                r_state        <= S_SETTLE;
                r_settle_cnt   <= SETTLE_W'(SETTLE_CYC - 1);
                r_good_cnt     <= '0;
                r_iter_count   <= '0;
                r_best_opening <= '0;
                r_adapt_busy   <= 1'b1;
                r_adapt_done   <= 1'b0;
                r_adapt_fail   <= 1'b0;
                r_fail_timeout <= 1'b0;
            end else begin
                unique case (r_state)
                    S_SETTLE: begin
                        if (w_settle_zero) begin
                            r_state         <= S_MEASURE;
                            r_tmo_cnt       <= '0;
                            r_measure_start <= 1'b1;
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 1'b1;
                        end
                    end

                    S_MEASURE: begin
                        // A ready strobe beats a timeout landing in the same cycle
                        if (bus.opening_ready) begin
                            if (bus.opening > r_best_opening) begin
                                r_best_opening <= bus.opening;
                            end
                            r_good_cnt <= w_good_next;
                            if (w_converged) begin
                                r_state      <= S_DONE;
                                r_adapt_busy <= 1'b0;
                                r_adapt_done <= 1'b1;
                            end else if (w_iter_limit) begin
                                r_state        <= S_FAIL;
                                r_adapt_busy   <= 1'b0;
                                r_adapt_fail   <= 1'b1;
                                r_fail_timeout <= 1'b0;
                            end else begin
                                r_state      <= S_UPDATE;
                                r_update_en  <= 1'b1;
                                r_iter_count <= r_iter_count + 1'b1;
                            end
                        end else if (w_tmo_hit) begin
                            r_state        <= S_FAIL;
                            r_adapt_busy   <= 1'b0;
                            r_adapt_fail   <= 1'b1;
                            r_fail_timeout <= 1'b1;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
                    end

                    S_UPDATE: begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= SETTLE_W'(SETTLE_CYC - 1);
                    end

                    default: begin
                        // IDLE, DONE and FAIL hold until start or abort
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.measure_start = r_measure_start;
    assign bus.update_en     = r_update_en;
    assign bus.adapt_busy    = r_adapt_busy;
    assign bus.adapt_done    = r_adapt_done;
    assign bus.adapt_fail    = r_adapt_fail;
    assign bus.fail_timeout  = r_fail_timeout;
    assign bus.iter_count    = r_iter_count;
    assign bus.best_opening  = r_best_opening;

endmodule

// File: tb/tb_eq_adapt_sequencer.sv
// Directed bench for eq_adapt_sequencer with hand-computed expectations.
module tb_eq_adapt_sequencer;

    logic clock;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   upd_cnt = 0;
    int   ms_cnt  = 0;

    eq_adapt_sequencer_if #(.OPEN_W(16), .ITER_W(6)) bus ();

    eq_adapt_sequencer #(
        .OPEN_W       (16),
        .TARGET       (16'd1000),
        .SETTLE_CYC   (4),
        .MEAS_TIMEOUT (10),
        .CONV_COUNT   (2),
        .MAX_ITER     (3),
        .ITER_W       (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe counters, sampled on the falling edge
    always @(negedge clock) begin
        if (bus.update_en)     upd_cnt++;
        if (bus.measure_start) ms_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_meas(input string tag, output int n);
        n = 0;
        while (!bus.measure_start && n < 100) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.measure_start), 1);
    endtask

    // Wait for measure_start, then return an opening two cycles later
    task automatic meas(input string tag, input logic [15:0] val);
        int n;
        wait_meas(tag, n);
        tick();
        tick();
        bus.opening       = val;
        bus.opening_ready = 1'b1;
        tick();
        bus.opening_ready = 1'b0;
        bus.opening       = '0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(bus.adapt_done || bus.adapt_fail) && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.adapt_done | bus.adapt_fail), 1);
    endtask

    initial begin
        int n;
        int base_upd;
        int base_ms;

        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.opening       = '0;
        bus.opening_ready = 1'b0;
        reset             = 1'b1;
        #12;
        check_eq("rst_busy",  32'(bus.adapt_busy), 0);
        check_eq("rst_done",  32'(bus.adapt_done), 0);
        check_eq("rst_fail",  32'(bus.adapt_fail), 0);
        check_eq("rst_iter",  32'(bus.iter_count), 0);
        check_eq("rst_best",  32'(bus.best_opening), 0);
        reset = 1'b0;
        tick();

        // 1: two good measurements converge after one update
        base_upd = upd_cnt;
        do_start();
        check_eq("s1_busy", 32'(bus.adapt_busy), 1);
        wait_meas("s1_ms1", n);
        check_eq("s1_ms_lat", 32'(n), 4);
        tick();
        tick();
        bus.opening       = 16'd1200;
        bus.opening_ready = 1'b1;
        tick();
        bus.opening_ready = 1'b0;
        meas("s1_ms2", 16'd1300);
        wait_end("s1_end");
        check_eq("s1_done", 32'(bus.adapt_done), 1);
        check_eq("s1_fail", 32'(bus.adapt_fail), 0);
        check_eq("s1_busy_end", 32'(bus.adapt_busy), 0);
        check_eq("s1_iter", 32'(bus.iter_count), 1);
        check_eq("s1_best", 32'(bus.best_opening), 1300);
        check_eq("s1_upd", 32'(upd_cnt - base_upd), 1);

        // 2: all below target -> iteration-limit failure
        base_upd = upd_cnt;
        do_start();
        check_eq("s2_done_drop", 32'(bus.adapt_done), 0);
        meas("s2_m1", 16'd500);
        meas("s2_m2", 16'd600);
        meas("s2_m3", 16'd700);
        meas("s2_m4", 16'd800);
        wait_end("s2_end");
        check_eq("s2_fail", 32'(bus.adapt_fail), 1);
        check_eq("s2_tmo", 32'(bus.fail_timeout), 0);
        check_eq("s2_iter", 32'(bus.iter_count), 3);
        check_eq("s2_best", 32'(bus.best_opening), 800);
        check_eq("s2_upd", 32'(upd_cnt - base_upd), 3);

        // 3: no opening_ready -> timeout 10 cycles after measure_start
        base_upd = upd_cnt;
        do_start();
        check_eq("s3_fail_drop", 32'(bus.adapt_fail), 0);
        wait_meas("s3_ms", n);
        check_eq("s3_ms_lat", 32'(n), 4);
        n = 0;
        while (!bus.adapt_fail && n < 50) begin
            tick();
            n++;
        end
        check_eq("s3_fail_lat", 32'(n), 10);
        check_eq("s3_tmo", 32'(bus.fail_timeout), 1);
        check_eq("s3_upd", 32'(upd_cnt - base_upd), 0);
        check_eq("s3_iter", 32'(bus.iter_count), 0);

        // 4: good count resets on 900; convergence wins over iteration limit
        base_upd = upd_cnt;
        do_start();
        check_eq("s4_tmo_clr", 32'(bus.fail_timeout), 0);
        // stray strobe during SETTLE must be ignored
        bus.opening       = 16'd5000;
        bus.opening_ready = 1'b1;
        tick();
        bus.opening_ready = 1'b0;
        bus.opening       = '0;
        meas("s4_m1", 16'd1100);
        meas("s4_m2", 16'd900);
        meas("s4_m3", 16'd1050);
        check_eq("s4_busy_mid", 32'(bus.adapt_busy), 1);
        meas("s4_m4", 16'd1200);
        wait_end("s4_end");
        check_eq("s4_done", 32'(bus.adapt_done), 1);
        check_eq("s4_fail", 32'(bus.adapt_fail), 0);
        check_eq("s4_iter", 32'(bus.iter_count), 3);
        check_eq("s4_best", 32'(bus.best_opening), 1200);
        check_eq("s4_upd", 32'(upd_cnt - base_upd), 3);

        // 5: abort in SETTLE after two updates
        do_start();
        meas("s5_m1", 16'd500);
        meas("s5_m2", 16'd500);
        check_eq("s5_upd_now", 32'(bus.update_en), 1);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_eq("s5_busy", 32'(bus.adapt_busy), 0);
        check_eq("s5_iter", 32'(bus.iter_count), 2);
        check_eq("s5_best", 32'(bus.best_opening), 500);
        base_ms = ms_cnt;
        repeat (8) tick();
        check_eq("s5_idle_ms", 32'(ms_cnt - base_ms), 0);
        do_start();
        check_eq("s5_iter_clr", 32'(bus.iter_count), 0);
        check_eq("s5_busy_rst", 32'(bus.adapt_busy), 1);

        // 6: asynchronous reset mid-MEASURE
        wait_meas("s6_ms", n);
        tick();
        bus.opening = 16'd1500;
        #3;
        reset = 1'b1;
        #1;
        check_eq("s6_busy", 32'(bus.adapt_busy), 0);
        check_eq("s6_iter", 32'(bus.iter_count), 0);
        check_eq("s6_ms0", 32'(bus.measure_start), 0);
        tick();
        reset = 1'b0;
        base_ms = ms_cnt;
        bus.opening_ready = 1'b1;
        tick();
        bus.opening_ready = 1'b0;
        bus.opening       = '0;
        tick();
        check_eq("s6_best", 32'(bus.best_opening), 0);
        check_eq("s6_idle", 32'(bus.adapt_busy), 0);
        check_eq("s6_done", 32'(bus.adapt_done), 0);
        check_eq("s6_no_ms", 32'(ms_cnt - base_ms), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
